// File: rtl/neuron_mac_relu.sv
// neuron_mac_relu: streams numWeight activations against a weight ROM, multiply-accumulates,
// then adds bias, saturates and applies ReLU once per frame.
module neuron_mac_relu #(
    parameter int numWeight    = 30,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12,
    parameter int addressWidth = $clog2(numWeight),
    parameter int accWidth     = 2*dataWidth+$clog2(numWeight)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [dataWidth-1:0]    in_data,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    bias,
    output logic                    w_ren,
    output logic [addressWidth-1:0] w_radd,
    input  logic [dataWidth-1:0]    w_dout,
    output logic [dataWidth-1:0]    out_data,
    output logic                    out_valid,
    output logic                    busy
);
    localparam logic signed [accWidth:0] maxv = (accWidth+1)'(2**(dataWidth-1)-1);
    logic [addressWidth-1:0] cnt;
    logic last0, v1, last1, done2;
    logic signed [dataWidth-1:0] d1, b_r;
    logic signed [accWidth-1:0] acc, sum_r, prod, mac;
    logic signed [accWidth:0] biased, t;
    logic [dataWidth-1:0] res;
    assign last0  = cnt == addressWidth'(numWeight-1);
    assign w_ren  = in_valid && !rst;
    assign w_radd = cnt;
    assign busy   = cnt != '0;
    assign prod   = accWidth'(d1) * accWidth'($signed(w_dout));
    assign mac    = acc + prod;
    // bias is latched with the last input so the next frame may change it immediately
    assign biased = (accWidth+1)'(sum_r) + ((accWidth+1)'(b_r) <<< fracBits);
    assign t      = biased >>> fracBits;
    assign res    = t < 0 ? '0 : t > maxv ? maxv[dataWidth-1:0] : t[dataWidth-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            d1        <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            b_r       <= '0;
            acc       <= '0;
            sum_r     <= '0;
            done2     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) cnt <= last0 ? '0 : cnt + 1'b1;
            if (in_valid && last0) b_r <= bias;
            d1    <= in_data;
            v1    <= in_valid;
            last1 <= in_valid && last0;
            if (v1) acc <= last1 ? '0 : mac;
            if (v1 && last1) sum_r <= mac;
            done2     <= v1 && last1;
            out_valid <= done2;
            if (done2) out_data <= res;
        end
    end
endmodule

// File: tb/tb_neuron_mac_relu.sv
// tb_neuron_mac_relu: randomized and directed frames checked against an arithmetic neuron model.
module tb_neuron_mac_relu;
    localparam int N = 30;
    logic clk = 0, rst = 1, in_valid = 0, w_ren, out_valid, busy;
    logic [15:0] in_data = 0, bias = 0, w_dout, out_data, last_out = 0;
    logic [4:0] w_radd;
    logic [15:0] wmem [N];
    logic [15:0] exp_q [$];
    int cyc_q [$];
    int errors = 0, checks = 0, midx = 0, cyc = 0, pulses = 0;
    longint acc_m = 0;

    neuron_mac_relu dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .bias(bias),
        .w_ren(w_ren), .w_radd(w_radd), .w_dout(w_dout),
        .out_data(out_data), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_ren) w_dout <= wmem[w_radd];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (out_valid) begin
        pulses++;
        last_out = out_data;
        if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
        else begin
            check("out_data", out_data, exp_q.pop_front());
            check("latency", cyc, cyc_q.pop_front());
        end
    end

    task automatic send(input logic [15:0] d);
        longint t;
        check("busy", busy, midx != 0);
        in_valid = 1;
        in_data = d;
        #1;
        check("w_ren", w_ren, 1);
        check("w_radd", w_radd, midx);
        acc_m += longint'(shortint'(d)) * longint'(shortint'(wmem[midx]));
        if (midx == N-1) begin
            t = (acc_m + (longint'(shortint'(bias)) * 4096)) >>> 12;
            exp_q.push_back(t < 0 ? 16'h0 : t > 32767 ? 16'h7FFF : t[15:0]);
            cyc_q.push_back(cyc + 3);
            midx = 0;
            acc_m = 0;
        end else midx++;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            #1 check("w_ren_idle", w_ren, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] d, input bit rnd, input int maxgap);
        for (int i = 0; i < N; i++) begin
            send(rnd ? 16'($urandom) : d);
            if (i < N-1) gap($urandom_range(0, maxgap));
        end
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) begin
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            check("rst_w_ren", w_ren, 0);
            check("rst_busy", busy, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
        end
        rst = 0;
        in_valid = 0;
        midx = 0;
        acc_m = 0;
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < N; i++) wmem[i] = w;
    endtask

    initial begin
        fill(16'h1000);
        do_reset();
        bias = 0;
        frame(16'h0100, 0, 0);
        gap(5);
        check("pos_frame", last_out, 16'h1E00);
        fill(16'hF000);
        bias = 16'h0800;
        pulses = 0;
        frame(16'h0100, 0, 2);
        gap(5);
        check("neg_frame", last_out, 16'h0000);
        check("neg_pulse", pulses, 1);
        fill(16'h7FFF);
        bias = 16'h7FFF;
        frame(16'h7FFF, 0, 1);
        gap(5);
        check("sat_frame", last_out, 16'h7FFF);
        fill(16'h1000);
        bias = 0;
        pulses = 0;
        frame(16'h0100, 0, 3);
        bias = 16'h1000;
        frame(16'h0100, 0, 0);
        gap(5);
        check("b2b_pulses", pulses, 2);
        check("b2b_frame_b", last_out, 16'h2E00);
        bias = 0;
        for (int i = 0; i < 10; i++) send(16'h0100);
        pulses = 0;
        do_reset();
        frame(16'h0100, 0, 1);
        gap(5);
        check("midrst_frame", last_out, 16'h1E00);
        check("midrst_pulses", pulses, 1);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) wmem[i] = (f % 2) ? 16'($urandom_range(0, 16'h1FFF)) - 16'h1000 : 16'($urandom);
            bias = 16'($urandom);
            frame(16'h0, 1, 2);
            gap($urandom_range(0, 4));
        end
        gap(6);
        check("pending_outputs", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
